disp4_scan_ctrl: RTL and testbench

Sequencing controller for the board's four 7-segment digits. It accepts a binary value through a load/busy handshake and converts it to four BCD digits with an iterative shift-add-3 converter. It then holds the digits and time-multiplexes them onto one shared segment bus with one-hot anode selects. It replaces per-digit static decode wiring so that only 7+4 pins drive the display.

---
 rtl/disp4_pkg.sv | 33 +++
 rtl/disp4_scan_ctrl_if.sv | 13 +
 rtl/bin2bcd_iter.sv | 51 +++++
 rtl/disp4_scan_ctrl.sv | 109 ++++++++++
 tb/tb_disp4_scan_ctrl.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/disp4_pkg.sv
// Shared types and constants for the four-digit multiplexed 7-segment controller.
// Segment encodings are active-low, bit 0 = segment a .. bit 6 = segment g.
package disp4_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        UPDT
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam int         MAX_DEC   = 9999;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/disp4_scan_ctrl_if.sv
// Load/busy handshake between a value producer and the display controller.
interface disp4_scan_ctrl_if #(
    parameter int N_IN = 14
);
    logic [N_IN-1:0] bin_in;
    logic            load;
    logic            busy;
    logic            done;
    logic            ovf;

    modport master (output bin_in, load, input busy, done, ovf);
    modport slave  (input bin_in, load, output busy, done, ovf);
endinterface

// File: rtl/bin2bcd_iter.sv
// Iterative shift-add-3 binary to 4-digit BCD converter, one bit per cycle.
// done is high during the final shift; bcd holds the result from the next cycle on.
module bin2bcd_iter #(
    parameter int N_IN = 14
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [N_IN-1:0] bin,
    output logic            busy,
    output logic            done,
    output logic [15:0]     bcd
);
    localparam int CNT_W = $clog2(N_IN + 1);

    logic [N_IN-1:0]  sh;
    logic [CNT_W-1:0] step;
    logic [15:0]      adj;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    assign done = busy && (step == CNT_W'(N_IN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh   <= '0;
            bcd  <= '0;
            step <= '0;
            busy <= 1'b0;
        end else if (start && !busy) begin
            sh   <= bin;
            bcd  <= '0;
            step <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            // Bits carried out of the thousands nibble are dropped; >9999 is flagged by the caller.
            bcd  <= {adj[14:0], sh[N_IN-1]};
            sh   <= {sh[N_IN-2:0], 1'b0};
            step <= step + CNT_W'(1);
            if (done)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/disp4_scan_ctrl.sv
// Four-digit 7-segment controller: load handshake, BCD conversion, held display
// registers and a free-running scan that multiplexes one digit per REFRESH_DIV cycles.
module disp4_scan_ctrl
    import disp4_pkg::*;
#(
    parameter int N_IN        = 14,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                clk,
    input  logic                rst_n,
    disp4_scan_ctrl_if.slave    bus,
    input  logic                blank_lz,
    output logic [6:0]          seg,
    output logic [3:0]          an
);
    localparam int PRE_W = $clog2(REFRESH_DIV);

    state_t      state, state_nxt;
    logic        accept;
    logic        conv_busy, conv_done;
    logic [15:0] conv_bcd;
    logic        ovf_pend, ovf_q, done_q;
    logic [3:0]  disp [4];

    logic [PRE_W-1:0] presc;
    logic [1:0]       idx;
    logic [3:0]       lz;
    logic [6:0]       seg_nxt;

    assign accept = (state == IDLE) && bus.load;

    bin2bcd_iter #(.N_IN(N_IN)) u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept),
        .bin   (bus.bin_in),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.load)  state_nxt = CONV;
            CONV:    if (conv_done) state_nxt = UPDT;
            UPDT:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_pend <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            for (int i = 0; i < 4; i++) disp[i] <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept)
                ovf_pend <= (32'(bus.bin_in) > MAX_DEC);
            if (state == UPDT) begin
                for (int i = 0; i < 4; i++) disp[i] <= conv_bcd[4*i +: 4];
                ovf_q  <= ovf_pend;
                done_q <= 1'b1;
            end
        end
    end

    assign bus.busy = (state != IDLE) || conv_busy;
    assign bus.done = done_q;
    assign bus.ovf  = ovf_q;

    // A digit is a leading zero when it and every higher digit are zero; units never qualifies.
    assign lz[3] = (disp[3] == 4'd0);
    assign lz[2] = lz[3] && (disp[2] == 4'd0);
    assign lz[1] = lz[2] && (disp[1] == 4'd0);
    assign lz[0] = 1'b0;

    always_comb begin
        seg_nxt = seg_decode(disp[idx]);
        if (ovf_q)
            seg_nxt = SEG_DASH;
        else if (blank_lz && lz[idx])
            seg_nxt = SEG_BLANK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
            seg   <= SEG_BLANK;
            an    <= 4'hF;
        end else if (presc == PRE_W'(REFRESH_DIV - 1)) begin
            presc <= '0;
            idx   <= idx + 2'd1;
            seg   <= seg_nxt;
            an    <= ~(4'b0001 << idx);
        end else begin
            presc <= presc + PRE_W'(1);
        end
    end

endmodule

// File: tb/tb_disp4_scan_ctrl.sv
// Directed bench for disp4_scan_ctrl with a short refresh divider.
module tb_disp4_scan_ctrl;

    localparam int N_IN = 14;
    localparam int RD   = 4;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       blank_lz = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;

    disp4_scan_ctrl_if #(.N_IN(N_IN)) bus ();

    disp4_scan_ctrl #(.N_IN(N_IN), .REFRESH_DIV(RD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .blank_lz (blank_lz),
        .seg      (seg),
        .an       (an)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    logic [6:0] slot_seg [4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Returns half a cycle after the edge that samples the load.
    task automatic start_load(input int v);
        @(negedge clk);
        bus.bin_in = N_IN'(v);
        bus.load   = 1'b1;
        @(negedge clk);
        bus.load   = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic grab_scan(input string tag);
        logic [3:0] prev;
        logic [3:0] seen;
        int         viol;
        repeat (5) @(negedge clk);
        seen = '0;
        viol = 0;
        prev = an;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (an != prev && prev != 4'hF && an != {prev[2:0], prev[3]}) viol++;
            prev = an;
            case (an)
                4'b1110: begin slot_seg[0] = seg; seen[0] = 1'b1; end
                4'b1101: begin slot_seg[1] = seg; seen[1] = 1'b1; end
                4'b1011: begin slot_seg[2] = seg; seen[2] = 1'b1; end
                4'b0111: begin slot_seg[3] = seg; seen[3] = 1'b1; end
                default: ;
            endcase
        end
        chk({tag, "_seen"}, 32'(seen), 32'hF);
        chk({tag, "_order"}, viol, 0);
    endtask

    task automatic chk_slots(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e2, input logic [6:0] e3);
        grab_scan(tag);
        chk({tag, "_u"}, 32'(slot_seg[0]), 32'(e0));
        chk({tag, "_t"}, 32'(slot_seg[1]), 32'(e1));
        chk({tag, "_h"}, 32'(slot_seg[2]), 32'(e2));
        chk({tag, "_k"}, 32'(slot_seg[3]), 32'(e3));
    endtask

    initial begin
        int n;
        int dones;
        bus.bin_in = '0;
        bus.load   = 1'b0;

        #23;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_ovf",  32'(bus.ovf), 0);
        chk("rst_seg",  32'(seg), 32'h7F);
        chk("rst_an",   32'(an), 32'hF);

        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (an == 4'hF && n < 10) begin @(negedge clk); n++; end
        chk("first_scan_lat", n, RD);
        chk("first_scan_an",  32'(an), 32'hE);
        chk("first_scan_seg", 32'(seg), 32'h40);

        // 1234, no blanking
        start_load(1234);
        chk("busy_1234", 32'(bus.busy), 1);
        wait_done(n);
        chk("lat_1234", n, 15);
        chk("ovf_1234", 32'(bus.ovf), 0);
        @(negedge clk);
        chk("done_pulse", 32'(bus.done), 0);
        chk("idle_busy", 32'(bus.busy), 0);
        chk_slots("d1234", 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001);

        // 7 with and without leading-zero blanking
        blank_lz = 1'b1;
        start_load(7);
        wait_done(n);
        chk("lat_7", n, 15);
        chk_slots("d7_blank", 7'b1111000, 7'h7F, 7'h7F, 7'h7F);
        blank_lz = 1'b0;
        chk_slots("d7_zero", 7'b1111000, 7'b1000000, 7'b1000000, 7'b1000000);

        // overflow then recovery
        blank_lz = 1'b1;
        start_load(10000);
        wait_done(n);
        chk("ovf_set", 32'(bus.ovf), 1);
        chk_slots("d_ovf", 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111);
        start_load(42);
        wait_done(n);
        chk("ovf_clr", 32'(bus.ovf), 0);
        chk_slots("d42", 7'b0100100, 7'b0011001, 7'h7F, 7'h7F);

        // load while busy is ignored
        start_load(5);
        @(negedge clk);
        bus.bin_in = N_IN'(9999);
        bus.load   = 1'b1;
        @(negedge clk);
        bus.load   = 1'b0;
        dones = 0;
        repeat (30) begin @(negedge clk); if (bus.done) dones++; end
        chk("busy_load_dones", dones, 1);
        chk_slots("d5", 7'b0010010, 7'h7F, 7'h7F, 7'h7F);

        // load during the update cycle is ignored
        start_load(6);
        repeat (14) @(negedge clk);
        bus.bin_in = N_IN'(9999);
        bus.load   = 1'b1;
        @(negedge clk);
        bus.load   = 1'b0;
        chk("updt_done", 32'(bus.done), 1);
        dones = 0;
        repeat (25) begin @(negedge clk); if (bus.done) dones++; end
        chk("updt_load_dones", dones, 0);
        chk_slots("d6", 7'b0000010, 7'h7F, 7'h7F, 7'h7F);

        // load in the cycle carrying done is accepted
        start_load(3);
        wait_done(n);
        chk("lat_3", n, 15);
        bus.bin_in = N_IN'(9999);
        bus.load   = 1'b1;
        @(negedge clk);
        bus.load   = 1'b0;
        chk("busy_after_done", 32'(bus.busy), 1);
        wait_done(n);
        chk("lat_9999", n, 15);
        chk_slots("d9999", 7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000);

        // reset in the middle of a conversion
        blank_lz = 1'b0;
        start_load(8888);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_an",   32'(an), 32'hF);
        chk("mid_rst_seg",  32'(seg), 32'h7F);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        n = 0;
        while (an == 4'hF && n < 10) begin
            @(negedge clk);
            n++;
            if (bus.done) dones++;
        end
        chk("rst_scan_lat", n, RD);
        chk("rst_scan_an",  32'(an), 32'hE);
        chk("rst_scan_seg", 32'(seg), 32'h40);
        repeat (20) begin @(negedge clk); if (bus.done) dones++; end
        chk("rst_no_done", dones, 0);
        chk("rst_ovf", 32'(bus.ovf), 0);

        // zero with blanking keeps a single 0
        blank_lz = 1'b1;
        start_load(0);
        wait_done(n);
        chk("lat_0", n, 15);
        chk_slots("d0", 7'b1000000, 7'h7F, 7'h7F, 7'h7F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
